// File: rtl/mesh_pkg.sv
// Shared constants and state encoding for the 8x8 MAC mesh sequencer.
// Imported by the sequencer RTL and its bench.
package mesh_pkg;

  localparam int DW        = 32;
  localparam int N         = 8;
  localparam int KW        = 16;
  localparam int CONF_TR   = 0;
  localparam int CONF_RELU = 1;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    DRAIN
  } state_e;

endpackage

// File: rtl/mesh_seq_if.sv
// Operand and result beat streams of the mesh sequencer.
// The sequencer is the slave: it sinks operand beats and sources result beats.
interface mesh_seq_if #(
  parameter int DW = 32,
  parameter int N  = 8
);

  logic                   in_valid;
  logic                   in_ready;
  logic [N*DW-1:0]        in_w;
  logic [N*DW-1:0]        in_x;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(N)-1:0]   out_col;
  logic [N*DW-1:0]        out_z;

  modport slave (
    input  in_valid,
    input  in_w,
    input  in_x,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_col,
    output out_z
  );

  modport master (
    output in_valid,
    output in_w,
    output in_x,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_col,
    input  out_z
  );

endinterface

// File: rtl/skew_line.sv
// Enable-gated delay line of DEPTH words; DEPTH=0 is a plain wire.
// Used for the input skew and the output deskew of the mesh.
module skew_line #(
  parameter int DW    = 32,
  parameter int DEPTH = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = &{1'b0, clk, rst_n, en};
    assign dout = din;
  end else begin : g_sr
    logic [DW-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
      end else if (en) begin
        sr[0] <= din;
        for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
      end
    end

    assign dout = sr[DEPTH-1];
  end

endmodule

// File: rtl/mesh_seq.sv
// Sequencer for the 8x8 systolic MAC mesh: feeds skewed operand beats,
// flushes, fires the row shifts and deskews the rows into result beats.
module mesh_seq #(
  parameter int DW = 32,
  parameter int N  = 8,
  parameter int KW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [KW-1:0]   cfg_k,
  input  logic [3:0]      cfg_conf,
  output logic            busy,
  output logic            done,
  mesh_seq_if.slave       io,
  output logic            m_enable,
  output logic            m_reset,
  output logic [3:0]      m_conf,
  output logic [N*DW-1:0] m_w_in,
  output logic [N*DW-1:0] m_x_in,
  output logic [N*DW-1:0] m_y_in,
  output logic [N-1:0]    m_clear_in,
  output logic [N-1:0]    m_shift,
  input  logic [N*DW-1:0] m_z_out
);

  import mesh_pkg::*;

  localparam int CW = $clog2(N);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, cnt_q;
  logic [3:0]      conf_q;
  logic            done_q, mrst_q;
  logic            step, last_beat, last_hs;
  logic            clr_src;
  logic [N*DW-1:0] w_src, x_src, z_dsk;

  // cnt_q counts beats in FEED, then steps from the FLUSH step on
  assign io.out_valid = (state_q == DRAIN) && (cnt_q >= KW'(2*N));
  assign io.out_col   = CW'(cnt_q - KW'(2*N));
  assign io.out_z     = z_dsk;

  assign last_beat = (state_q == FEED) && io.in_valid
                   && (cnt_q == k_q - KW'(1));
  assign last_hs   = io.out_valid && io.out_ready
                   && (cnt_q == KW'(3*N-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && cfg_k != '0) state_d = FEED;
      FEED:    if (last_beat) state_d = FLUSH;
      FLUSH:   state_d = DRAIN;
      DRAIN:   if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    step        = 1'b0;
    io.in_ready = 1'b0;
    unique case (state_q)
      FEED: begin
        io.in_ready = 1'b1;
        step        = io.in_valid;
      end
      FLUSH:   step = 1'b1;
      DRAIN:   step = !io.out_valid || io.out_ready;
      default: step = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q    <= '0;
      cnt_q  <= '0;
      conf_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_hs
             || (state_q == IDLE && start && cfg_k == '0);
      if (state_q == IDLE) begin
        cnt_q <= '0;
        if (start && cfg_k != '0) begin
          k_q    <= cfg_k;
          conf_q <= cfg_conf;
        end
      end else if (step) begin
        cnt_q <= last_beat ? '0 : cnt_q + KW'(1);
      end
    end
  end

  // mesh reset is held one clock past reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mrst_q <= 1'b1;
    else        mrst_q <= 1'b0;
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign m_enable = step;
  assign m_reset  = mrst_q;
  assign m_conf   = conf_q;
  assign m_y_in   = '0;

  assign w_src   = (state_q == FEED) ? io.in_w : '0;
  assign x_src   = (state_q == FEED) ? io.in_x : '0;
  assign clr_src = (state_q == FEED && cnt_q == '0)
                || (state_q == FLUSH);

  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_line #(.DW(DW), .DEPTH(g)) u_w (
      .clk   (clk),
      .rst_n (reset),
      .en    (step),
      .din   (w_src[g*DW +: DW]),
      .dout  (m_w_in[g*DW +: DW])
    );

    skew_line #(.DW(DW), .DEPTH(g)) u_x (
      .clk   (clk),
      .rst_n (reset),
      .en    (step),
      .din   (x_src[g*DW +: DW]),
      .dout  (m_x_in[g*DW +: DW])
    );

    skew_line #(.DW(1), .DEPTH(g)) u_c (
      .clk   (clk),
      .rst_n (reset),
      .en    (step),
      .din   (clr_src),
      .dout  (m_clear_in[g])
    );

    skew_line #(.DW(DW), .DEPTH(N-1-g)) u_z (
      .clk   (clk),
      .rst_n (reset),
      .en    (step),
      .din   (m_z_out[g*DW +: DW]),
      .dout  (z_dsk[g*DW +: DW])
    );

    assign m_shift[g] = (state_q == DRAIN)
                     && (cnt_q == KW'(g + N));
  end

endmodule

// File: tb/tb_mesh_seq.sv
// Bench for mesh_seq: behavioural integer MAC mesh plus matrix golden model,
// randomized stalls and data, reset and edge cases.
module tb_mesh_seq;

  import mesh_pkg::*;

  logic            clk;
  logic            reset;
  logic            start;
  logic [KW-1:0]   cfg_k;
  logic [3:0]      cfg_conf;
  logic            busy, done;
  logic            m_enable, m_reset;
  logic [3:0]      m_conf;
  logic [N*DW-1:0] m_w_in, m_x_in, m_y_in, m_z_out;
  logic [N-1:0]    m_clear_in, m_shift;

  mesh_seq_if #(.DW(DW), .N(N)) io ();

  mesh_seq #(.DW(DW), .N(N), .KW(KW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_k      (cfg_k),
    .cfg_conf   (cfg_conf),
    .busy       (busy),
    .done       (done),
    .io         (io),
    .m_enable   (m_enable),
    .m_reset    (m_reset),
    .m_conf     (m_conf),
    .m_w_in     (m_w_in),
    .m_x_in     (m_x_in),
    .m_y_in     (m_y_in),
    .m_clear_in (m_clear_in),
    .m_shift    (m_shift),
    .m_z_out    (m_z_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int en_cnt  = 0;
  int done_cnt = 0;

  logic [DW-1:0] wb [8][N];
  logic [DW-1:0] xb [8][N];

  task automatic check(input string tag,
                       input logic [N*DW-1:0] got,
                       input logic [N*DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] lane(input logic [N*DW-1:0] v,
                                         input int i);
    return v[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] relu_f(input logic en,
                                           input logic [DW-1:0] v);
    return (en && v[DW-1]) ? '0 : v;
  endfunction

  // Output-stationary integer MAC mesh: W down columns, X across rows
  logic [DW-1:0] acc [N][N];
  logic [DW-1:0] stb [N][N];
  logic [DW-1:0] wr  [N][N];
  logic [DW-1:0] xr  [N][N];
  logic [DW-1:0] zc  [N][N];
  logic          cr  [N][N];

  function automatic logic [DW-1:0] w_at(input int i, input int j);
    if (i == 0) return lane(m_w_in, j);
    return wr[i-1][j];
  endfunction

  function automatic logic [DW-1:0] x_at(input int i, input int j);
    if (j == 0) return lane(m_x_in, i);
    return xr[i][j-1];
  endfunction

  function automatic logic c_at(input int i, input int j);
    if (i == 0) return m_clear_in[j];
    return cr[i-1][j];
  endfunction

  function automatic logic [DW-1:0] z_next(input int i, input int j);
    if (m_shift[i])
      return relu_f(m_conf[CONF_RELU],
                    m_conf[CONF_TR] ? stb[j][i] : stb[i][j]);
    if (j == N-1) return '0;
    return zc[i][j+1];
  endfunction

  always @(posedge clk) begin
    if (m_reset) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= '0; stb[i][j] <= '0; wr[i][j] <= '0;
          xr[i][j]  <= '0; zc[i][j]  <= '0; cr[i][j] <= 1'b0;
        end
    end else if (m_enable) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          wr[i][j] <= w_at(i, j);
          xr[i][j] <= x_at(i, j);
          cr[i][j] <= c_at(i, j);
          zc[i][j] <= z_next(i, j);
          if (c_at(i, j)) begin
            stb[i][j] <= acc[i][j];
            acc[i][j] <= w_at(i, j) * x_at(i, j);
          end else begin
            acc[i][j] <= acc[i][j] + w_at(i, j) * x_at(i, j);
          end
        end
    end
  end

  always_comb begin
    m_z_out = '0;
    for (int i = 0; i < N; i++) m_z_out[i*DW +: DW] = zc[i][0];
  end

  always @(posedge clk) begin
    if (m_enable) en_cnt <= en_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // Result beat j, lane i = C[i][j] from the job's operand beats
  function automatic logic [N*DW-1:0] gold(input int j, input int k,
                                           input logic [3:0] conf);
    logic [N*DW-1:0] r;
    logic [DW-1:0]   a;
    r = '0;
    for (int i = 0; i < N; i++) begin
      a = '0;
      for (int b = 0; b < k; b++)
        a += conf[CONF_TR] ? wb[b][i] * xb[b][j] : xb[b][i] * wb[b][j];
      r[i*DW +: DW] = relu_f(conf[CONF_RELU], a);
    end
    return r;
  endfunction

  function automatic logic [N*DW-1:0] pk(input int b, input bit isw);
    logic [N*DW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      r[i*DW +: DW] = isw ? wb[b][i] : xb[b][i];
    return r;
  endfunction

  task automatic fill_identity();
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < N; i++) begin
        wb[b][i] = (i == b) ? 32'd1 : 32'd0;
        xb[b][i] = 32'(8*b + i + 1);
      end
  endtask

  task automatic fill_relu();
    for (int i = 0; i < N; i++) begin
      wb[0][i] = 32'hFFFF_FFFF;
      xb[0][i] = 32'd2;
    end
  endtask

  task automatic fill_rand(input int k);
    for (int b = 0; b < k; b++)
      for (int i = 0; i < N; i++) begin
        wb[b][i] = 32'($urandom_range(0, 511)) - 32'd256;
        xb[b][i] = 32'($urandom_range(0, 511)) - 32'd256;
      end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_inrdy", io.in_ready, 0);
    check("rst_ovld",  io.out_valid, 0);
    check("rst_men",   m_enable, 0);
    check("rst_mconf", m_conf, 0);
    check("rst_mrst",  m_reset, 1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("mrst_hold", m_reset, 1);
    @(negedge clk);
    check("mrst_rel", m_reset, 0);
  endtask

  task automatic run_job(input int k, input logic [3:0] conf,
                         input int vpct, input int rpct,
                         input bit poke, input bit abort);
    int b, j, guard, en0, d0;
    bit hs, stalled;
    logic [N*DW-1:0] hold;
    en0 = en_cnt;
    d0  = done_cnt;
    @(negedge clk);
    start = 1'b1; cfg_k = KW'(k); cfg_conf = conf;
    @(negedge clk);
    start = 1'b0;
    check("busy_start", busy, 1);
    check("m_conf", m_conf, conf);
    b = 0; guard = 0;
    while (b < k && guard < 1000) begin
      io.in_valid = ($urandom_range(0, 99) < vpct);
      io.in_w = pk(b, 1);
      io.in_x = pk(b, 0);
      start = poke && (b == 1);
      cfg_k = KW'(5);
      #1 hs = io.in_valid && io.in_ready;
      @(negedge clk);
      if (hs) b++;
      guard++;
    end
    io.in_valid = 1'b0;
    start = 1'b0;
    if (b < k) begin
      check("feed_timeout", b, k);
      return;
    end
    j = 0; guard = 0; stalled = 0; hold = '0;
    while (j < N && guard < 1000) begin
      io.out_ready = ($urandom_range(0, 99) < rpct);
      #1;
      if (abort && io.out_valid) begin
        io.out_ready = 1'b0;
        return;
      end
      if (io.out_valid) begin
        if (stalled) check("z_hold", io.out_z, hold);
        check("out_col", io.out_col, j);
        check("out_z", io.out_z, gold(j, k, conf));
        hold = io.out_z;
        stalled = !io.out_ready;
        if (io.out_ready) j++;
      end
      @(negedge clk);
      guard++;
    end
    io.out_ready = 1'b0;
    if (j < N) begin
      check("drain_timeout", j, N);
      return;
    end
    check("done", done, 1);
    check("busy_end", busy, 0);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("done_once", done_cnt - d0, 1);
    check("steps", en_cnt - en0, k + 3*N);
  endtask

  int en0, d0, kr;

  initial begin
    reset = 1'b0; start = 1'b0; cfg_k = '0; cfg_conf = '0;
    io.in_valid = 1'b0; io.in_w = '0; io.in_x = '0;
    io.out_ready = 1'b0;
    do_reset();

    fill_identity();
    run_job(8, 4'b0000, 100, 100, 0, 0);

    fill_relu();
    run_job(1, 4'b0010, 100, 100, 0, 0);
    run_job(1, 4'b0000, 100, 100, 0, 0);

    fill_identity();
    run_job(8, 4'b0000, 50, 50, 0, 0);

    fill_rand(3);
    run_job(3, 4'b0000, 100, 100, 1, 0);
    fill_rand(5);
    run_job(5, 4'b0000, 100, 100, 0, 0);

    en0 = en_cnt;
    @(negedge clk);
    start = 1'b1; cfg_k = '0; cfg_conf = 4'b0011;
    @(negedge clk);
    start = 1'b0;
    check("k0_done", done, 1);
    check("k0_busy", busy, 0);
    check("k0_ovld", io.out_valid, 0);
    check("k0_mconf", m_conf, 0);
    @(negedge clk);
    check("k0_pulse", done, 0);
    check("k0_steps", en_cnt - en0, 0);

    fill_rand(4);
    run_job(4, 4'b0010, 100, 0, 0, 1);
    d0 = done_cnt;
    do_reset();
    check("abort_nodone", done_cnt - d0, 0);
    fill_identity();
    run_job(8, 4'b0000, 100, 100, 0, 0);

    run_job(8, 4'b0001, 100, 100, 0, 0);

    repeat (4) begin
      kr = $urandom_range(1, 8);
      fill_rand(kr);
      run_job(kr, 4'($urandom_range(0, 3)), 70, 70, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
